layer_sequencer: RTL
====================

Name: layer_sequencer

Overview:
Top-level scheduler for the LeNet accelerator. It runs the per-layer controllers (conv/pool/fc, each driven by a level `enable` and reporting a sticky `conv_done`) strictly in order for one frame. It flips the ping-pong feature buffer between layers and re-arms each layer controller with a clear pulse. It sits above the per-layer control blocks and below the host/DMA frame interface.

Parameters:
- NUM_LAYERS, 5, number of layer controllers sequenced; index 0 runs first.
- LAYER_IDX_WIDTH, 3, width of cur_layer; must satisfy 2^LAYER_IDX_WIDTH >= NUM_LAYERS.
- DRAIN_CYCLES, 4, idle cycles after a layer's done, before clear, to flush the mult/accum pipeline; range 1..15.
- FRAME_CNT_WIDTH, 16, width of frame_count.
- TIMEOUT_CYCLES, 1000000, watchdog limit per layer (used only with the optional feature).
- TIMEOUT_WIDTH, 20, width of the watchdog counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- net_start  in  1  frame request; level-sampled in IDLE only
- net_busy  out  1  high in every state except IDLE
- net_done  out  1  one-cycle pulse when the last layer is cleared
- layer_enable  out  NUM_LAYERS  one-hot level enable to the layer controllers
- layer_clear  out  NUM_LAYERS  one-hot one-cycle synchronous re-arm pulse
- layer_done  in  NUM_LAYERS  sticky done from each layer controller
- buf_sel  out  1  ping-pong select; layer reads bank buf_sel and writes bank ~buf_sel
- cur_layer  out  LAYER_IDX_WIDTH  index of the active layer
- frame_count  out  FRAME_CNT_WIDTH  number of completed frames, wraps
- error  out  2  sticky flags: bit0 stale done, bit1 watchdog timeout

Behaviour:
- Moore FSM. All outputs are registered or decoded from registered state only.
- Reset values: state IDLE, all outputs 0, internal counters 0.
- States and transitions:
  - IDLE: if net_start=1, go to ARM with cur_layer<=0. All other inputs are ignored.
  - ARM (1 cycle minimum): if layer_done[cur]=1 (stale), set error[0], pulse layer_clear[cur], and stay in ARM. Otherwise go to RUN.
  - RUN: layer_enable[cur]=1. When layer_done[cur]=1, go to DRAIN with the drain counter loaded to DRAIN_CYCLES-1.
  - DRAIN: layer_enable=0. Decrement the counter; at 0 go to CLEAR.
  - CLEAR (1 cycle): pulse layer_clear[cur] and toggle buf_sel. If cur_layer==NUM_LAYERS-1 go to FINISH; else cur_layer+1 and go to ARM.
  - FINISH (1 cycle): net_done=1, frame_count+1 (wraps to 0), then IDLE. buf_sel is not reset between frames.
- Latency: net_start sampled at edge k gives layer_enable[0] high after edge k+2.
- Per layer, layer_done high at edge j gives:
  - layer_enable low after edge j+1;
  - layer_clear after edge j+1+DRAIN_CYCLES.
- Input-handling rules:
  - layer_done of non-current layers is ignored in all states.
  - net_start during busy is ignored; it is not queued.
  - Simultaneous error conditions set both bits.
  - error clears only on reset.
- Asynchronous reset mid-frame returns to IDLE immediately with all enables and clears low. Layer controllers are assumed to share the same reset.

Optional Feature:
- Macro LAYER_SEQ_WATCHDOG_EN.
- When defined:
  - A TIMEOUT_WIDTH counter runs in RUN and reloads on entry to ARM.
  - Reaching TIMEOUT_CYCLES sets error[1] and goes to state ABORT.
  - ABORT (1 cycle): layer_enable=0, layer_clear all ones, then IDLE. There is no net_done and frame_count is unchanged.
- When undefined: no counter, no ABORT state, error[1] tied to 0.

Decomposition:
- Shared package/header layer_seq_pkg holds:
  - the state encoding constants (IDLE, ARM, RUN, DRAIN, CLEAR, FINISH, ABORT);
  - the error bit indices;
  - default NUM_LAYERS / DRAIN_CYCLES, alongside the existing layer param headers.
- One natural sub-module: seq_down_counter, a loadable down-counter with a zero flag. It is reused for drain and for the watchdog.

Test Plan:
- NUM_LAYERS=3, DRAIN_CYCLES=2; pulse net_start; model each layer raising done 10 cycles after its enable -> enables 001, 010, 100 in order; three clear pulses; buf_sel toggles 3 times; net_done once; frame_count=1.
- Hold net_start high through 2 frames -> net_start ignored mid-frame; exactly 2 net_done pulses; frame_count=2; buf_sel ends at 0 after 6 toggles (even).
- Assert layer_done[1] while layer 0 runs -> no effect; layer 1 then enters ARM with done high -> error[0]=1, clear pulse issued, RUN entered only after done drops.
- Assert reset 3 cycles into layer 1 RUN -> next cycle all outputs 0, state IDLE; a new net_start restarts at layer 0.
- With LAYER_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES=50, never raise done -> error[1] set at RUN cycle 50, layer_clear=111 for one cycle, IDLE, no net_done.
- frame_count preset path with FRAME_CNT_WIDTH=2, run 4 frames -> counts 1, 2, 3, 0.

Source files
------------

// File: rtl/layer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_seq_pkg
// Purpose  : Shared definitions for the LeNet layer sequencer: state
//            encoding, error flag bit positions and default sizing.
//            The ABORT state exists only when LAYER_SEQ_WATCHDOG_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
package layer_seq_pkg;

  // Default sizing, kept next to the per-layer parameter headers.
  localparam int DEF_NUM_LAYERS   = 5;
  localparam int DEF_DRAIN_CYCLES = 4;

  // Drain counter width: DRAIN_CYCLES is limited to 1..15.
  localparam int DRAIN_CNT_WIDTH  = 4;

  // Bit positions inside the sticky error vector.
  localparam int ERR_STALE_DONE   = 0;
  localparam int ERR_TIMEOUT      = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_FINISH = 3'd5
`ifdef LAYER_SEQ_WATCHDOG_EN
    ,
    ST_ABORT  = 3'd6
`endif
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_down_counter
// Purpose  : Loadable down-counter with a zero flag. Saturates at zero.
//            Used by the layer sequencer for pipeline drain and for the
//            optional per-layer watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module seq_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins over decrement; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Purpose  : Frame-level scheduler for the LeNet accelerator. Runs each
//            layer controller in order (arm, run, drain, clear), flips the
//            ping-pong feature buffer between layers and counts frames.
//            All layer-facing outputs are registered from the state.
//            Optional: LAYER_SEQ_WATCHDOG_EN adds a per-layer timeout that
//            aborts the frame and raises error[1].
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_LAYERS      = DEF_NUM_LAYERS,
  parameter int LAYER_IDX_WIDTH = 3,
  parameter int DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int TIMEOUT_WIDTH   = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       net_start_i,
  output logic                       net_busy_o,
  output logic                       net_done_o,
  output logic [NUM_LAYERS-1:0]      layer_enable_o,
  output logic [NUM_LAYERS-1:0]      layer_clear_o,
  input  logic [NUM_LAYERS-1:0]      layer_done_i,
  output logic                       buf_sel_o,
  output logic [LAYER_IDX_WIDTH-1:0] cur_layer_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count_o,
  output logic [1:0]                 error_o
);

  seq_state_t                 state_q,       state_d;
  logic [LAYER_IDX_WIDTH-1:0] cur_layer_q,   cur_layer_d;
  logic [NUM_LAYERS-1:0]      enable_q,      enable_d;
  logic [NUM_LAYERS-1:0]      clear_q,       clear_d;
  logic                       buf_sel_q,     buf_sel_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                       net_done_q,    net_done_d;
  logic [1:0]                 error_q,       error_d;

  logic [NUM_LAYERS-1:0]      cur_sel;
  logic                       cur_done;
  logic                       cur_is_last;
  logic                       clear_pending;

  logic                       drain_load;
  logic                       drain_dec;
  logic                       drain_zero;

  // One-hot select of the current layer; other layers' done is masked off.
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_cur_sel
    assign cur_sel[gi] = (cur_layer_q == LAYER_IDX_WIDTH'(gi));
  end

  assign cur_done      = |(layer_done_i & cur_sel);
  assign clear_pending = |(clear_q & cur_sel);
  assign cur_is_last   = (cur_layer_q == LAYER_IDX_WIDTH'(NUM_LAYERS - 1));

  seq_down_counter #(
    .WIDTH (DRAIN_CNT_WIDTH)
  ) u_drain_cnt (
    .clock        (clock),
    .reset        (reset),
    .load_i       (drain_load),
    .load_value_i (DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1)),
    .dec_i        (drain_dec),
    .zero_o       (drain_zero)
  );

`ifdef LAYER_SEQ_WATCHDOG_EN
  logic wd_load;
  logic wd_dec;
  logic wd_zero;

  // Loaded with TIMEOUT_CYCLES-1 so the zero flag is seen in RUN cycle
  // TIMEOUT_CYCLES.
  seq_down_counter #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog_cnt (
    .clock        (clock),
    .reset        (reset),
    .load_i       (wd_load),
    .load_value_i (TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)),
    .dec_i        (wd_dec),
    .zero_o       (wd_zero)
  );
`else
  logic unused_wd_params;
  assign unused_wd_params = (TIMEOUT_CYCLES == 0) ^ (TIMEOUT_WIDTH == 0);
`endif

  // Next-state and next-output decode; outputs reflect the state one cycle
  // later because they are registered from the current state.
  always_comb begin
    state_d       = state_q;
    cur_layer_d   = cur_layer_q;
    enable_d      = '0;
    clear_d       = '0;
    buf_sel_d     = buf_sel_q;
    frame_count_d = frame_count_q;
    net_done_d    = 1'b0;
    error_d       = error_q;
    drain_load    = 1'b0;
    drain_dec     = 1'b0;
`ifdef LAYER_SEQ_WATCHDOG_EN
    wd_load       = 1'b0;
    wd_dec        = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (net_start_i) begin
          state_d     = ST_ARM;
          cur_layer_d = '0;
`ifdef LAYER_SEQ_WATCHDOG_EN
          wd_load     = 1'b1;
`endif
        end
      end
      ST_ARM: begin
        // A done left over from an earlier run: flag it and re-arm the
        // layer. One clear pulse per pending done, the layer needs a cycle
        // to drop done after seeing it.
        if (cur_done) begin
          error_d[ERR_STALE_DONE] = 1'b1;
          if (!clear_pending) begin
            clear_d = cur_sel;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        enable_d = cur_sel;
`ifdef LAYER_SEQ_WATCHDOG_EN
        wd_dec   = 1'b1;
`endif
        if (cur_done) begin
          state_d    = ST_DRAIN;
          drain_load = 1'b1;
        end
`ifdef LAYER_SEQ_WATCHDOG_EN
        else if (wd_zero) begin
          error_d[ERR_TIMEOUT] = 1'b1;
          state_d              = ST_ABORT;
        end
`endif
      end
      ST_DRAIN: begin
        if (drain_zero) begin
          state_d = ST_CLEAR;
        end else begin
          drain_dec = 1'b1;
        end
      end
      ST_CLEAR: begin
        clear_d   = cur_sel;
        buf_sel_d = ~buf_sel_q;
        if (cur_is_last) begin
          state_d = ST_FINISH;
        end else begin
          cur_layer_d = cur_layer_q + LAYER_IDX_WIDTH'(1);
          state_d     = ST_ARM;
`ifdef LAYER_SEQ_WATCHDOG_EN
          wd_load     = 1'b1;
`endif
        end
      end
      ST_FINISH: begin
        net_done_d    = 1'b1;
        frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
        state_d       = ST_IDLE;
      end
`ifdef LAYER_SEQ_WATCHDOG_EN
      ST_ABORT: begin
        clear_d = '1;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset drops all enables.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_layer_q   <= '0;
      enable_q      <= '0;
      clear_q       <= '0;
      buf_sel_q     <= 1'b0;
      frame_count_q <= '0;
      net_done_q    <= 1'b0;
      error_q       <= '0;
    end else begin
      state_q       <= state_d;
      cur_layer_q   <= cur_layer_d;
      enable_q      <= enable_d;
      clear_q       <= clear_d;
      buf_sel_q     <= buf_sel_d;
      frame_count_q <= frame_count_d;
      net_done_q    <= net_done_d;
      error_q       <= error_d;
    end
  end

  assign net_busy_o     = (state_q != ST_IDLE);
  assign net_done_o     = net_done_q;
  assign layer_enable_o = enable_q;
  assign layer_clear_o  = clear_q;
  assign buf_sel_o      = buf_sel_q;
  assign cur_layer_o    = cur_layer_q;
  assign frame_count_o  = frame_count_q;
  assign error_o        = error_q;

endmodule
`default_nettype wire
